// File: rtl/icache_way_array.sv
// icache_way_array: N-way set-associative instruction-cache line storage.
// Holds per-way valid/tag/line data and a tree pseudo-LRU state per set.
// Provides a one-cycle registered lookup with victim selection on a miss,
// a refill write port, and a one-set-per-cycle invalidate sweep for fence.i.
module icache_way_array #(
    parameter int WAYS      = 4,
    parameter int SETS      = 16,
    parameter int IDX_LEN   = $clog2(SETS),
    parameter int WAY_LEN   = (WAYS > 1 ? $clog2(WAYS) : 1),
    parameter int TAG_LEN   = 22,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookup_valid,
    output logic                 lookup_ready,
    input  logic [IDX_LEN-1:0]   lookup_index,
    input  logic [TAG_LEN-1:0]   lookup_tag,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic [WAY_LEN-1:0]   resp_way,
    output logic [LINE_BITS-1:0] resp_data,
    input  logic                 refill_valid,
    input  logic [IDX_LEN-1:0]   refill_index,
    input  logic [WAY_LEN-1:0]   refill_way,
    input  logic [TAG_LEN-1:0]   refill_tag,
    input  logic [LINE_BITS-1:0] refill_data,
    input  logic                 flush_req,
    output logic                 flush_busy
);

    // state    | meaning
    // ST_IDLE  | lookups and refills serviced
    // ST_FLUSH | invalidate sweep, one set per cycle, all other requests blocked
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // A direct-mapped array has no replacement tree; keep one dummy bit so
    // the vectors stay legal.
    localparam int LEVELS = (WAYS > 1) ? $clog2(WAYS) : 0;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    // Counter is one bit wider than the index so the last set is a plain
    // compare and the increment past it cannot alias set 0.
    localparam logic [IDX_LEN:0] CNT_LAST = (IDX_LEN + 1)'(SETS - 1);

    logic [0:0]                     state_q, state_d;
    logic [IDX_LEN:0]               cnt_q, cnt_d;
    logic [SETS-1:0][WAYS-1:0]      valid_q, valid_d;
    logic [SETS-1:0][PLRU_W-1:0]    plru_q, plru_d;
    logic                           resp_valid_q, resp_valid_d;
    logic                           resp_hit_q, resp_hit_d;
    logic [WAY_LEN-1:0]             resp_way_q, resp_way_d;
    logic [LINE_BITS-1:0]           resp_data_q, resp_data_d;
    logic                           flush_busy_q, flush_busy_d;

    // Tags and line data are plain storage and are never reset.
    logic [TAG_LEN-1:0]             tag_mem  [SETS][WAYS];
    logic [LINE_BITS-1:0]           data_mem [SETS][WAYS];

    logic                           lookup_fire;
    logic                           refill_fire;
    logic                           look_hit;
    logic [WAY_LEN-1:0]             look_hit_way;
    logic [LINE_BITS-1:0]           look_hit_data;
    logic                           look_inv;
    logic [WAY_LEN-1:0]             look_inv_way;
    logic [WAY_LEN-1:0]             look_victim;

    // Tree nodes are numbered heap-style (root 0, children 2n+1 / 2n+2).
    // A node bit of 1 means the LRU side, and hence the victim, is the right
    // subtree. Touching a way makes every node on its path point away from it.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_LEN-1:0] way);
        logic [PLRU_W-1:0] r;
        int wi;
        int node;
        int dir;
        r  = bits;
        wi = int'(way);
        for (int l = 0; l < LEVELS; l++) begin
            node = (1 << l) - 1 + (wi >> (LEVELS - l));
            dir  = (wi >> (LEVELS - 1 - l)) & 1;
            for (int n = 0; n < PLRU_W; n++) begin
                if (n == node) r[n] = (dir == 0);
            end
        end
        return r;
    endfunction

    function automatic logic [WAY_LEN-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        int node;
        int v;
        int b;
        node = 0;
        v    = 0;
        for (int l = 0; l < LEVELS; l++) begin
            b = 0;
            for (int n = 0; n < PLRU_W; n++) begin
                if (n == node) b = int'(bits[n]);
            end
            v    = (v << 1) | b;
            node = 2 * node + 1 + b;
        end
        return WAY_LEN'(v);
    endfunction

    assign lookup_ready = (state_q == ST_IDLE) & ~refill_valid & ~flush_req;
    assign lookup_fire  = lookup_valid & lookup_ready;
    assign refill_fire  = refill_valid & (state_q == ST_IDLE);

    // Tag compare and victim choice for the set being looked up; descending
    // scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        look_hit      = 1'b0;
        look_hit_way  = '0;
        look_hit_data = '0;
        look_inv      = 1'b0;
        look_inv_way  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[lookup_index][w] && (tag_mem[lookup_index][w] == lookup_tag)) begin
                look_hit      = 1'b1;
                look_hit_way  = WAY_LEN'(w);
                look_hit_data = data_mem[lookup_index][w];
            end
            if (!valid_q[lookup_index][w]) begin
                look_inv     = 1'b1;
                look_inv_way = WAY_LEN'(w);
            end
        end
        look_victim = look_inv ? look_inv_way : plru_victim(plru_q[lookup_index]);
    end

    // Sequencer, valid bits and replacement state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        plru_d  = plru_q;
        case (state_q)
            ST_IDLE: begin
                if (refill_fire) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (refill_way == WAY_LEN'(w)) valid_d[refill_index][w] = 1'b1;
                    end
                    plru_d[refill_index] = plru_touch(plru_q[refill_index], refill_way);
                end
                if (lookup_fire && look_hit) begin
                    plru_d[lookup_index] = plru_touch(plru_q[lookup_index], look_hit_way);
                end
                if (flush_req) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                valid_d[cnt_q[IDX_LEN-1:0]] = '0;
                plru_d[cnt_q[IDX_LEN-1:0]]  = '0;
                cnt_d                       = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response register: captures the lookup result at the accept edge.
    always_comb begin
        resp_valid_d = lookup_fire;
        resp_hit_d   = resp_hit_q;
        resp_way_d   = resp_way_q;
        resp_data_d  = resp_data_q;
        if (lookup_fire) begin
            resp_hit_d  = look_hit;
            resp_way_d  = look_hit ? look_hit_way : look_victim;
            resp_data_d = look_hit ? look_hit_data : '0;
        end
        flush_busy_d = (state_d == ST_FLUSH);
    end

    // Control and response flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            valid_q      <= '0;
            plru_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            resp_data_q  <= '0;
            flush_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            plru_q       <= plru_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_way_q   <= resp_way_d;
            resp_data_q  <= resp_data_d;
            flush_busy_q <= flush_busy_d;
        end
    end

    // Tag/data write port for refills.
    always_ff @(posedge clk) begin
        if (!rst && refill_fire) begin
            for (int w = 0; w < WAYS; w++) begin
                if (refill_way == WAY_LEN'(w)) begin
                    tag_mem[refill_index][w]  <= refill_tag;
                    data_mem[refill_index][w] <= refill_data;
                end
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_way   = resp_way_q;
    assign resp_data  = resp_data_q;
    assign flush_busy = flush_busy_q;

endmodule

// File: doc/icache_way_array.md
Name: icache_way_array

Overview:
- Parametrised N-way set-associative instruction-cache storage block; successor to the single-way direct-mapped line array.
- Holds per-way valid/tag/128-bit line data and a tree pseudo-LRU state per set.
- Supports a one-cycle registered lookup, a refill write with victim selection, and a sequenced fence.i invalidate sweep.
- Sits between the icache control FSM (lookup/refill) and the fetch stage (response data).

Parameters:
- WAYS, 4, number of ways; power of two, 1..8.
- SETS, 16, number of sets; power of two, >=2.
- IDX_LEN, $clog2(SETS), set index width.
- WAY_LEN, (WAYS>1 ? $clog2(WAYS) : 1), way number width.
- TAG_LEN, 22, tag width.
- LINE_BITS, 128, line data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- lookup_valid  in  1  lookup request
- lookup_ready  out  1  lookup accepted this cycle when valid&ready
- lookup_index  in  IDX_LEN  set index
- lookup_tag  in  TAG_LEN  tag to compare
- resp_valid  out  1  lookup result valid
- resp_hit  out  1  tag matched a valid way
- resp_way  out  WAY_LEN  hit way, or victim way on miss
- resp_data  out  LINE_BITS  hit line data; zero on miss
- refill_valid  in  1  write line
- refill_index  in  IDX_LEN  set to write
- refill_way  in  WAY_LEN  way to write (normally the resp_way of the miss)
- refill_tag  in  TAG_LEN  tag to store
- refill_data  in  LINE_BITS  line to store
- flush_req  in  1  start invalidate-all (fence.i)
- flush_busy  out  1  sweep in progress

Behaviour:
- Reset (rst=1 at a clk edge):
  - All valid bits and PLRU bits are cleared.
  - FSM goes to IDLE.
  - resp_valid=0, resp_hit=0, resp_way=0, resp_data=0, flush_busy=0.
  - Tags and data are not reset.
  - A reset asserted during a sweep aborts it; all valids are still cleared.
- FSM states: IDLE, FLUSH.
  - IDLE -> FLUSH on flush_req; the internal sweep counter is set to 0.
  - In FLUSH, one set per cycle: the valid bits of every way in set cnt are cleared and that set's PLRU bits are cleared; cnt increments.
  - FLUSH -> IDLE after set SETS-1 is cleared, giving exactly SETS cycles of flush_busy=1.
  - flush_busy is a registered output equal to (state==FLUSH).
  - flush_req while in FLUSH is ignored.
- lookup_ready = (state==IDLE) & ~refill_valid & ~flush_req. Refill and flush both take priority over a lookup in the same cycle.
- Lookup, accepted at edge N:
  - At edge N+1: resp_valid=1.
  - resp_hit = OR over ways of (valid & tag==lookup_tag).
  - resp_way = the matching way. If several ways match (illegal), the lowest index wins.
  - resp_data = that way's line.
  - resp_valid is 1 for exactly one cycle per accepted lookup; back-to-back lookups give back-to-back responses.
- Miss victim, as reported in resp_way:
  - If any way in the set is invalid, the lowest-index invalid way.
  - Otherwise the tree-PLRU victim.
  - resp_data=0 on a miss.
  - WAYS=1 always gives way 0.
- PLRU:
  - Tree of WAYS-1 bits per set.
  - Updated at the lookup edge on a hit and at the refill edge, marking the touched way most-recently-used; each tree node bit is set to point away from that way.
  - Misses do not update the PLRU.
- Refill, accepted when state==IDLE:
  - Writes tag/data into (refill_index, refill_way) and sets that valid bit at the edge.
  - A lookup of the same line on the following cycle hits with the new data; there is no bypass within the same cycle.
- refill_valid while in FLUSH is dropped: no write and no PLRU change.
- refill_valid and flush_req in the same IDLE cycle: the refill is performed, then the sweep starts the next cycle and therefore invalidates that line.
- Sweep counter wraps cleanly; IDX_LEN+1 bits are used so the terminal count is detected without overflow.

Test Plan (defaults WAYS=4, SETS=16, TAG_LEN=22):
- Reset, then lookup idx=3 tag=0x12345 -> next cycle resp_valid=1, resp_hit=0, resp_way=0, resp_data=0.
- Refill idx=3 way=2 tag=0x12345 data=0xDEADBEEF_..._0001, then lookup the same line -> resp_hit=1, resp_way=2, data matches; a lookup with tag 0x12346 -> miss, resp_way=0 (lowest invalid way).
- Fill ways 0..3 of set 5 in order, hit way 1, then look up a missing tag -> victim follows PLRU; with the tree bits after that sequence the victim is way 2.
- flush_req while refill_valid is asserted -> refill performed; flush_busy high for exactly 16 cycles; lookup_ready=0 throughout; refills in that window are dropped; afterwards all lookups miss.
- Refill and lookup asserted together -> lookup_ready=0 and the lookup is retried the next cycle, returning a hit; 8 back-to-back lookups -> 8 consecutive resp_valid pulses.
- Assert rst mid-flush at cycle 7 -> flush_busy=0 the next cycle and all sets are invalid; repeat the key tests with WAYS=1 and with WAYS=8.
